// File: rtl/uart_tx_arbiter_if.sv
// Request/grant bundle between up to four byte producers and the UART TX arbiter.
//   req           : per-requester transmit request (level), bit i = requester i
//   req_data      : byte of requester i on bits [8i+7:8i]
//   gnt           : one-hot, one-cycle grant/acknowledge pulse
//   uart_tx_start : start strobe towards uart_tx
//   uart_tx_input : byte towards uart_tx
//   busy          : high while a frame is owned or in flight
//   owner         : index of the current or most recent grantee
// Modport master is the requester side; modport slave is the arbiter side.
interface uart_tx_arbiter_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        uart_tx_start;
    logic [7:0]  uart_tx_input;
    logic        busy;
    logic [1:0]  owner;

    modport master (
        output req, req_data,
        input  gnt, uart_tx_start, uart_tx_input, busy, owner
    );

    modport slave (
        input  req, req_data,
        output gnt, uart_tx_start, uart_tx_input, busy, owner
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between four byte requesters.
// A grant loads the winner's byte, the next cycle strobes uart_tx_start, then the
// block waits one full frame (10 bits) plus an idle gap before arbitrating again.
//   clk   : single clock, rising edge
//   reset : synchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (req/req_data in; gnt/start/byte/busy/owner out)
// All outputs are registered.
module uart_tx_arbiter #(
    parameter int unsigned CLKS_PER_BIT = 20,
    parameter int unsigned GAP_CLKS     = 4
) (
    input logic              clk,
    input logic              reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned WaitClks = 10 * CLKS_PER_BIT + GAP_CLKS;
    localparam int unsigned CntW     = $clog2(WaitClks + 1);
    // WAIT spans WaitClks cycles: counter runs WaitClks-1 down to 0 inclusive.
    localparam logic [CntW-1:0] WaitLoad = CntW'(WaitClks - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      owner_q, owner_d;
    logic [3:0]      gnt_q, gnt_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic [7:0]      data_q, data_d;

    logic            found;
    logic [1:0]      winner;

    // Scan ptr, ptr+1, ... (mod 4); the 2-bit sum wraps naturally.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!found && bus.req[ptr_q + 2'(i)]) begin
                found  = 1'b1;
                winner = ptr_q + 2'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        data_d  = data_q;
        busy_d  = busy_q;
        gnt_d   = 4'b0000;
        start_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy_d = found;
                if (found) begin
                    gnt_d   = 4'b0001 << winner;
                    data_d  = bus.req_data[{winner, 3'b000} +: 8];
                    owner_d = winner;
                    ptr_d   = winner + 2'd1;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                start_d = 1'b1;
                cnt_d   = WaitLoad;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            gnt_q   <= 4'b0000;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.uart_tx_start = start_q;
    assign bus.uart_tx_input = data_q;
    assign bus.busy          = busy_q;
    assign bus.owner         = owner_q;
endmodule
